// File: rtl/eco_sweep_ctrl.sv
`timescale 1ns/1ps
// ============================================================================
// eco_sweep_ctrl
// ----------------------------------------------------------------------------
// Exhaustive stimulus sequencer and response compactor for small combinational
// ECO test netlists. Every {A,B} combination is driven into the netlist in
// ascending index order. Each Y response is folded into a 16-bit MISR. The
// final signature is compared with a golden value, so an original netlist and
// its ECO-patched version can be checked for equivalence.
//
// Parameters
//   A_W        width of dut_a
//   B_W        width of dut_b
//   Y_W        width of dut_y (must be <= SIG_W)
//   SIG_W      MISR width; the feedback taps are chosen for 16
//   SETTLE_CYC wait cycles between driving a vector and sampling Y (>= 0)
//   SEED       MISR value loaded when a sweep starts
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      begin a sweep; accepted only in IDLE or DONE
//   abort      cancel the sweep and return to IDLE; wins over start
//   golden_sig expected signature, sampled as the sweep enters DONE
//   dut_a/b    registered stimulus to the netlist
//   dut_y      netlist response
//   busy       sweep in progress
//   done       sweep complete; held until the next start or abort
//   sig        current MISR value
//   match      sig == golden_sig; meaningful while done=1
//   vec_cnt    number of vectors sampled in this sweep
//
// Optional feature (macro ECO_SWEEP_FAILLOG_EN)
//   exp_y      per-vector golden model response
//   fail_valid a mismatch between dut_y and exp_y has been captured
//   fail_idx   index of the first mismatching vector
// With the macro undefined these ports and their registers do not exist.
// ============================================================================
module eco_sweep_ctrl #(
    parameter int              A_W        = 5,
    parameter int              B_W        = 5,
    parameter int              Y_W        = 3,
    parameter int              SIG_W      = 16,
    parameter int              SETTLE_CYC = 1,
    parameter logic [SIG_W-1:0] SEED      = 16'h0001
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [SIG_W-1:0]   golden_sig,
    output logic [A_W-1:0]     dut_a,
    output logic [B_W-1:0]     dut_b,
    input  logic [Y_W-1:0]     dut_y,
    output logic               busy,
    output logic               done,
    output logic [SIG_W-1:0]   sig,
    output logic               match,
    output logic [A_W+B_W:0]   vec_cnt
`ifdef ECO_SWEEP_FAILLOG_EN
    ,
    input  logic [Y_W-1:0]     exp_y,
    output logic               fail_valid,
    output logic [A_W+B_W-1:0] fail_idx
`endif
);

    localparam int IDX_W       = A_W + B_W;
    localparam int VC_W        = IDX_W + 1;
    localparam int CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int SETTLE_LAST = (SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_settleCnt;
    logic [SIG_W-1:0]   r_sig;
    logic [VC_W-1:0]    r_vecCnt;
    logic [A_W-1:0]     r_dutA;
    logic [B_W-1:0]     r_dutB;
    logic               r_match;

    logic               w_startAcc;
    logic               w_isLast;
    logic               w_settleDone;
    logic               w_fb;
    logic [SIG_W-1:0]   w_misrNext;
    logic [IDX_W-1:0]   w_idxNext;

    // MISR step: shift left with the polynomial feedback into bit 0, then fold
    // in the zero-extended response. Because the feedback includes the top bit
    // the step is invertible, so a single flipped response bit always leaves a
    // different final signature.
    assign w_fb       = r_sig[SIG_W-1] ^ r_sig[SIG_W-3] ^ r_sig[SIG_W-4] ^ r_sig[SIG_W-6];
    assign w_misrNext = {r_sig[SIG_W-2:0], w_fb} ^ SIG_W'(dut_y);

    // The last vector is recognised from the index itself, so the index is
    // never advanced past it and the sweep cannot restart by wrapping.
    assign w_isLast     = &r_idx;
    assign w_idxNext    = r_idx + IDX_W'(1);
    assign w_settleDone = (r_settleCnt == CNT_W'(SETTLE_LAST));

    // State register; reset returns the sequencer to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and status decoding. busy and done come straight from the
    // current state so busy falls on exactly the cycle done rises. abort is
    // applied last so it overrides every transition, including start.
    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        w_startAcc  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = APPLY;
                    w_startAcc  = 1'b1;
                end
            end
            APPLY: begin
                busy        = 1'b1;
                w_nextState = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
            end
            SETTLE: begin
                busy = 1'b1;
                if (w_settleDone) begin
                    w_nextState = SAMPLE;
                end
            end
            SAMPLE: begin
                busy        = 1'b1;
                w_nextState = w_isLast ? DONE : APPLY;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_nextState = APPLY;
                    w_startAcc  = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        if (abort) begin
            w_nextState = IDLE;
            w_startAcc  = 1'b0;
        end
    end

    // Datapath. The stimulus registers are loaded on every transition into
    // APPLY (from start or from SAMPLE), so dut_a/dut_b already show vector i
    // during APPLY and stay unchanged through SETTLE and SAMPLE. abort clears
    // the stimulus and match but deliberately keeps the partial signature and
    // vector count visible for debug.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_settleCnt <= '0;
            r_sig       <= '0;
            r_vecCnt    <= '0;
            r_dutA      <= '0;
            r_dutB      <= '0;
            r_match     <= 1'b0;
        end else if (abort) begin
            r_settleCnt <= '0;
            r_dutA      <= '0;
            r_dutB      <= '0;
            r_match     <= 1'b0;
        end else if (w_startAcc) begin
            r_idx       <= '0;
            r_settleCnt <= '0;
            r_sig       <= SEED;
            r_vecCnt    <= '0;
            r_dutA      <= '0;
            r_dutB      <= '0;
            r_match     <= 1'b0;
        end else begin
            case (r_state)
                APPLY: begin
                    r_settleCnt <= '0;
                end
                SETTLE: begin
                    r_settleCnt <= r_settleCnt + CNT_W'(1);
                end
                SAMPLE: begin
                    r_sig    <= w_misrNext;
                    r_vecCnt <= r_vecCnt + VC_W'(1);
                    if (w_isLast) begin
                        r_match <= (w_misrNext == golden_sig);
                    end else begin
                        r_idx            <= w_idxNext;
                        {r_dutA, r_dutB} <= w_idxNext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dut_a   = r_dutA;
    assign dut_b   = r_dutB;
    assign sig     = r_sig;
    assign match   = r_match;
    assign vec_cnt = r_vecCnt;

`ifdef ECO_SWEEP_FAILLOG_EN
    logic               r_failValid;
    logic [IDX_W-1:0]   r_failIdx;

    // First-failure log: only the earliest mismatching index of a sweep is
    // kept; it survives into DONE and is cleared by start, abort or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_failValid <= 1'b0;
            r_failIdx   <= '0;
        end else if (abort || w_startAcc) begin
            r_failValid <= 1'b0;
            r_failIdx   <= '0;
        end else if ((r_state == SAMPLE) && (dut_y != exp_y) && !r_failValid) begin
            r_failValid <= 1'b1;
            r_failIdx   <= r_idx;
        end
    end

    assign fail_valid = r_failValid;
    assign fail_idx   = r_failIdx;
`endif

endmodule

// File: tb/tb_eco_sweep_ctrl.sv
`timescale 1ns/1ps
// ============================================================================
// tb_eco_sweep_ctrl
// ----------------------------------------------------------------------------
// Bench for eco_sweep_ctrl. A behavioural netlist model drives dut_y from the
// stimulus, with a random output mask and an optional single flipped response.
// A reference model tracks the sweep as "cycles since start": the vector index
// is cycle / (2 + SETTLE_CYC), and a response is folded in on the last cycle
// of each vector period. A compare process checks every output each cycle;
// literal expectations pin the model at a few known points.
// ============================================================================
module tb_eco_sweep_ctrl;

    localparam int          A_W        = 5;
    localparam int          B_W        = 5;
    localparam int          Y_W        = 3;
    localparam int          SIG_W      = 16;
    localparam int          SETTLE_CYC = 1;
    localparam int          NVEC       = 1 << (A_W + B_W);
    localparam int          PER        = 2 + SETTLE_CYC;
    localparam logic [15:0] SEED       = 16'h0001;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] goldenSig;
    logic [4:0]  dutA;
    logic [4:0]  dutB;
    logic [2:0]  dutY;
    logic        busy;
    logic        done;
    logic [15:0] sig;
    logic        match;
    logic [10:0] vecCnt;

    logic [2:0]  yMask;
    logic        flipEn;
    int          flipIdx;
    logic        flipHit;
    logic        chkEn;
    logic        pinEn;

    int          totalCnt;
    int          passCnt;

    // Reference model state.
    logic        mBusy      = 1'b0;
    logic        mDone      = 1'b0;
    logic        mMatch     = 1'b0;
    logic [15:0] mSig       = '0;
    int          mVec       = 0;
    int          mCyc       = 0;
    logic [4:0]  mA         = '0;
    logic [4:0]  mB         = '0;
    int          mK;
    logic [2:0]  mY;

`ifdef ECO_SWEEP_FAILLOG_EN
    logic [2:0]  expY;
    logic        expFlipEn;
    logic        expHit;
    logic        failValid;
    logic [9:0]  failIdx;
    logic        mFailValid = 1'b0;
    int          mFailIdx   = 0;
`endif

    eco_sweep_ctrl #(
        .A_W        (A_W),
        .B_W        (B_W),
        .Y_W        (Y_W),
        .SIG_W      (SIG_W),
        .SETTLE_CYC (SETTLE_CYC),
        .SEED       (SEED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .golden_sig (goldenSig),
        .dut_a      (dutA),
        .dut_b      (dutB),
        .dut_y      (dutY),
        .busy       (busy),
        .done       (done),
        .sig        (sig),
        .match      (match),
        .vec_cnt    (vecCnt)
`ifdef ECO_SWEEP_FAILLOG_EN
        ,
        .exp_y      (expY),
        .fail_valid (failValid),
        .fail_idx   (failIdx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the combinational netlist under test.
    function automatic logic [2:0] netFn(input logic [4:0] a, input logic [4:0] b,
                                         input logic [2:0] mask);
        logic [5:0] s;
        s = a + b;
        return s[2:0] ^ {a[4] & b[0], a[1] | b[3], a[0] ^ b[2]} ^ mask;
    endfunction

    function automatic logic [15:0] misrStep(input logic [15:0] s, input logic [2:0] y);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {13'b0, y};
    endfunction

    function automatic logic [2:0] modelY(input int k);
        logic [9:0] kk;
        kk = k[9:0];
        return netFn(kk[9:5], kk[4:0], yMask) ^ {2'b00, flipEn && (k == flipIdx)};
    endfunction

    assign flipHit = flipEn && (int'({dutA, dutB}) == flipIdx);
    assign dutY    = netFn(dutA, dutB, yMask) ^ {2'b00, flipHit};

`ifdef ECO_SWEEP_FAILLOG_EN
    function automatic logic [2:0] modelExp(input int k);
        logic [9:0] kk;
        kk = k[9:0];
        return netFn(kk[9:5], kk[4:0], yMask) ^ {2'b00, expFlipEn && (k == 300 || k == 700)};
    endfunction

    assign expHit = expFlipEn && ({dutA, dutB} == 10'd300 || {dutA, dutB} == 10'd700);
    assign expY   = netFn(dutA, dutB, yMask) ^ {2'b00, expHit};
`endif

    // Reference model: a sweep is a count of busy cycles; the vector on
    // display is cycle / PER and a response is folded in at the final cycle
    // of each period.
    always @(posedge clk) begin
        if (rst) begin
            mBusy = 1'b0; mDone = 1'b0; mMatch = 1'b0; mSig = '0; mVec = 0; mCyc = 0;
            mA = '0; mB = '0;
`ifdef ECO_SWEEP_FAILLOG_EN
            mFailValid = 1'b0; mFailIdx = 0;
`endif
        end else if (abort) begin
            mBusy = 1'b0; mDone = 1'b0; mMatch = 1'b0; mA = '0; mB = '0;
`ifdef ECO_SWEEP_FAILLOG_EN
            mFailValid = 1'b0; mFailIdx = 0;
`endif
        end else if (start && !mBusy) begin
            mBusy = 1'b1; mDone = 1'b0; mMatch = 1'b0; mSig = SEED; mVec = 0; mCyc = 0;
            mA = '0; mB = '0;
`ifdef ECO_SWEEP_FAILLOG_EN
            mFailValid = 1'b0; mFailIdx = 0;
`endif
        end else if (mBusy) begin
            mK = mCyc / PER;
            if (mCyc % PER == PER - 1) begin
                mY = modelY(mK);
`ifdef ECO_SWEEP_FAILLOG_EN
                if (mY != modelExp(mK) && !mFailValid) begin
                    mFailValid = 1'b1;
                    mFailIdx   = mK;
                end
`endif
                mSig = misrStep(mSig, mY);
                mVec = mVec + 1;
                if (mK == NVEC - 1) begin
                    mBusy  = 1'b0;
                    mDone  = 1'b1;
                    mMatch = (mSig == goldenSig);
                end
            end
            if (mBusy) begin
                mCyc = mCyc + 1;
                {mA, mB} = 10'(mCyc / PER);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end else begin
            passCnt++;
        end
    endtask

    // Per-cycle comparison of every output against the reference model.
    always @(negedge clk) begin
        if (chkEn) begin
            checkOutput("busy",    32'(busy),   32'(mBusy));
            checkOutput("done",    32'(done),   32'(mDone));
            checkOutput("dut_a",   32'(dutA),   32'(mA));
            checkOutput("dut_b",   32'(dutB),   32'(mB));
            checkOutput("sig",     32'(sig),    32'(mSig));
            checkOutput("vec_cnt", 32'(vecCnt), 32'(mVec));
            checkOutput("match",   32'(match),  32'(mMatch));
`ifdef ECO_SWEEP_FAILLOG_EN
            checkOutput("fail_valid", 32'(failValid), 32'(mFailValid));
            checkOutput("fail_idx",   32'(failIdx),   32'(mFailIdx));
`endif
        end
    end

    // Drive start/abort for one clock, launched and released on falling edges.
    task automatic applyStimulus(input logic s, input logic a);
        @(negedge clk);
        start = s;
        abort = a;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    // Wait for done with a cycle budget, counting busy cycles on the way.
    task automatic waitDone(input int budget, output int busyCyc);
        int n;
        n       = 0;
        busyCyc = 0;
        while (done !== 1'b1 && n < budget) begin
            if (busy === 1'b1) busyCyc++;
            if (pinEn && mBusy && mCyc == 37 * PER) begin
                checkOutput("idx37_a", 32'(dutA), 32'd1);
                checkOutput("idx37_b", 32'(dutB), 32'd5);
            end
            if (pinEn && mBusy && mCyc == 2 * PER) begin
                checkOutput("sig_after2", 32'(sig), 32'h0005);
                checkOutput("vec_after2", 32'(vecCnt), 32'd2);
            end
            @(negedge clk);
            n++;
        end
        checkOutput("done_reached", 32'(done), 32'd1);
    endtask

    task automatic runSweep(output int busyCyc);
        applyStimulus(1'b1, 1'b0);
        waitDone(4000, busyCyc);
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          bc;
        logic [15:0] run1Sig;

        totalCnt  = 0;
        passCnt   = 0;
        chkEn     = 1'b0;
        pinEn     = 1'b0;
        rst       = 1'b1;
        start     = 1'b1;
        abort     = 1'b0;
        goldenSig = '0;
        yMask     = '0;
        flipEn    = 1'b0;
        flipIdx   = 0;
`ifdef ECO_SWEEP_FAILLOG_EN
        expFlipEn = 1'b0;
`endif

        // Reset held two cycles with start high; nothing may start afterwards.
        @(negedge clk);
        chkEn = 1'b1;
        checkOutput("rst_busy", 32'(busy),   32'd0);
        checkOutput("rst_sig",  32'(sig),    32'd0);
        checkOutput("rst_vec",  32'(vecCnt), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("no_start_after_rst", 32'(busy), 32'd0);
        end

        // Two identical sweeps with a known mask and a random golden value.
        goldenSig = 16'($urandom);
        pinEn     = 1'b1;
        runSweep(bc);
        pinEn     = 1'b0;
        checkOutput("busy_cycles", 32'(bc), 32'd3072);
        checkOutput("final_vec", 32'(vecCnt), 32'd1024);
        checkOutput("final_a", 32'(dutA), 32'd31);
        run1Sig = mSig;
        runSweep(bc);
        checkOutput("rerun_sig", 32'(sig), 32'(run1Sig));

        // Golden equal to the reference signature, then a single flipped bit.
        goldenSig = run1Sig;
        runSweep(bc);
        checkOutput("golden_match", 32'(match), 32'd1);
        flipEn  = 1'b1;
        flipIdx = 100;
        runSweep(bc);
        checkOutput("flip_match", 32'(match), 32'd0);
        checkOutput("flip_done",  32'(done),  32'd1);
        flipEn = 1'b0;

        // Abort roughly 500 cycles into a sweep, then a clean rerun.
        applyStimulus(1'b1, 1'b0);
        repeat (498) @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_a",    32'(dutA), 32'd0);
        checkOutput("abort_b",    32'(dutB), 32'd0);
        runSweep(bc);
        checkOutput("after_abort_sig",   32'(sig),   32'(run1Sig));
        checkOutput("after_abort_match", 32'(match), 32'd1);

        // Reset in the middle of a sweep.
        applyStimulus(1'b1, 1'b0);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_busy", 32'(busy),   32'd0);
        checkOutput("midrst_sig",  32'(sig),    32'd0);
        checkOutput("midrst_vec",  32'(vecCnt), 32'd0);

        // Randomised masks, golden values and abort points.
        for (int r = 0; r < 2; r++) begin
            yMask     = 3'($urandom);
            goldenSig = 16'($urandom);
            applyStimulus(1'b1, 1'b0);
            repeat ($urandom_range(5, 3000)) @(negedge clk);
            applyStimulus(1'b0, 1'b1);
        end
        yMask     = 3'($urandom);
        goldenSig = 16'($urandom);
        flipEn    = 1'b1;
        flipIdx   = int'($urandom_range(0, NVEC - 1));
        runSweep(bc);
        flipEn    = 1'b0;
        yMask     = '0;

        // start held through a whole sweep: exactly one sweep, then a restart
        // from DONE on the following cycle.
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        start = 1'b1;
        waitDone(4000, bc);
        checkOutput("hold_busy_cycles", 32'(bc), 32'd3072);
        @(negedge clk);
        checkOutput("restart_busy", 32'(busy),   32'd1);
        checkOutput("restart_vec",  32'(vecCnt), 32'd0);
        start = 1'b0;
        applyStimulus(1'b0, 1'b1);

        // start and abort together in IDLE: abort wins.
        applyStimulus(1'b1, 1'b1);
        checkOutput("start_abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("start_abort_idle", 32'(busy), 32'd0);

`ifdef ECO_SWEEP_FAILLOG_EN
        // First-failure log: mismatches at 300 and 700, only 300 is kept.
        expFlipEn = 1'b1;
        runSweep(bc);
        checkOutput("faillog_valid", 32'(failValid), 32'd1);
        checkOutput("faillog_idx",   32'(failIdx),   32'd300);
        @(negedge clk);
        checkOutput("faillog_held",  32'(failIdx),   32'd300);
        applyStimulus(1'b1, 1'b0);
        checkOutput("faillog_clr_valid", 32'(failValid), 32'd0);
        checkOutput("faillog_clr_idx",   32'(failIdx),   32'd0);
        expFlipEn = 1'b0;
        applyStimulus(1'b0, 1'b1);
`endif

        @(negedge clk);
        chkEn = 1'b0;
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
